uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between N byte-stream sources: metadata sender, sample-readback streamer, and any future responders.
- Grants are message-locked: a source keeps the transmitter from grant until it drops its request, so bytes from different sources never interleave.
- Round-robin fairness between messages; a watchdog reclaims the transmitter from a stalled source.
- Sits between the per-source senders and the UART TX core; presents each source with the same tx_busy/send-strobe handshake the UART core provides.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream sources, the arbiter and the UART TX core.
// The arbiter takes the slave view; the source/UART side takes the master view.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_SRC = 2
);
  logic [N_SRC-1:0]   src_req;
  logic [8*N_SRC-1:0] src_byte;
  logic [N_SRC-1:0]   src_send;
  logic [N_SRC-1:0]   src_grant;
  logic [N_SRC-1:0]   src_tx_busy;
  logic               uart_tx_busy;
  logic [7:0]         uart_byte;
  logic               uart_send;
  logic [2:0]         active_src;

  modport master (
    output src_req, src_byte, src_send, uart_tx_busy,
    input  src_grant, src_tx_busy, uart_byte, uart_send, active_src
  );

  modport slave (
    input  src_req, src_byte, src_send, uart_tx_busy,
    output src_grant, src_tx_busy, uart_byte, uart_send, active_src
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Message-locked round-robin arbiter sharing one UART transmitter between N_SRC sources.
// A granted source owns the UART until it drops its request; a watchdog reclaims it from a
// stalled source and locks that source out until it releases its request.
module uart_tx_arbiter #(
  parameter int unsigned N_SRC          = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic              clock,
  input  logic              reset_n,
  uart_tx_arbiter_if.slave  bus,
  input  logic              err_clear,
  output logic              timeout_err,
  output logic              overrun_err
);

  typedef enum logic [1:0] {StIdle, StGranted, StDrain} state_e;

  state_e           state;
  logic [2:0]       rr_ptr;
  logic [15:0]      wd_cnt;
  logic [N_SRC-1:0] lockout;

  logic [N_SRC-1:0] req_ok;
  logic             hi_valid, lo_valid, pick_valid;
  logic [2:0]       hi_idx, lo_idx, pick_idx;
  logic [N_SRC-1:0] pick_onehot;
  logic [7:0]       byte_g;
  logic             req_g, send_g, busy_g, idle_g;
  logic             accept, overrun_set, wd_fire;
  logic [2:0]       next_ptr;

  // Grant is one-hot, so masking with it selects the granted source's signals.
  assign req_g  = |(bus.src_req & bus.src_grant);
  assign send_g = |(bus.src_send & bus.src_grant);
  assign busy_g = bus.uart_tx_busy | bus.uart_send;
  assign idle_g = ~busy_g & ~send_g;

  assign accept      = (state == StGranted) & send_g & ~busy_g;
  assign overrun_set = (state == StGranted) & send_g & busy_g;
  assign wd_fire     = (TIMEOUT_CYCLES != 16'd0) && (state == StGranted) && idle_g &&
                       (wd_cnt == TIMEOUT_CYCLES - 16'd1);

  assign req_ok   = bus.src_req & ~lockout;
  assign next_ptr = (bus.active_src == 3'(N_SRC - 1)) ? 3'd0 : bus.active_src + 3'd1;

  // Per-source busy view: only the granted source can ever see the UART as free.
  always_comb begin
    bus.src_tx_busy = '1;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (bus.src_grant[i]) bus.src_tx_busy[i] = busy_g;
    end
  end

  // Round-robin pick: lowest eligible index at or above rr_ptr, else lowest below it.
  always_comb begin
    hi_valid = 1'b0;
    hi_idx   = '0;
    lo_valid = 1'b0;
    lo_idx   = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req_ok[i]) begin
        if (i >= int'(rr_ptr)) begin
          hi_valid = 1'b1;
          hi_idx   = 3'(i);
        end else begin
          lo_valid = 1'b1;
          lo_idx   = 3'(i);
        end
      end
    end
  end

  assign pick_valid = hi_valid | lo_valid;
  assign pick_idx   = hi_valid ? hi_idx : lo_idx;

  // One-hot encode the pick and mux the granted source's byte.
  always_comb begin
    pick_onehot = '0;
    byte_g      = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      pick_onehot[i] = (3'(i) == pick_idx);
      if (bus.src_grant[i]) byte_g = byte_g | bus.src_byte[8*i +: 8];
    end
  end

  // Arbitration FSM with registered grant, UART strobe, watchdog and sticky error flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= StIdle;
      rr_ptr         <= '0;
      wd_cnt         <= '0;
      lockout        <= '0;
      bus.src_grant  <= '0;
      bus.active_src <= '0;
      bus.uart_send  <= 1'b0;
      bus.uart_byte  <= 8'h00;
      timeout_err    <= 1'b0;
      overrun_err    <= 1'b0;
    end else begin
      bus.uart_send <= 1'b0;
      wd_cnt        <= '0;
      // A lockout lasts until its source is seen with the request low.
      lockout <= (lockout & bus.src_req) | ({N_SRC{wd_fire & req_g}} & bus.src_grant);

      if (overrun_set)    overrun_err <= 1'b1;
      else if (err_clear) overrun_err <= 1'b0;
      if (wd_fire)        timeout_err <= 1'b1;
      else if (err_clear) timeout_err <= 1'b0;

      unique case (state)
        StIdle: begin
          if (pick_valid) begin
            bus.src_grant  <= pick_onehot;
            bus.active_src <= pick_idx;
            state          <= StGranted;
          end
        end
        StGranted: begin
          if (accept) begin
            bus.uart_byte <= byte_g;
            bus.uart_send <= 1'b1;
          end
          if (idle_g && !wd_fire) wd_cnt <= wd_cnt + 16'd1;
          // A strobe coinciding with the request drop is still forwarded above.
          if (!req_g || wd_fire) begin
            bus.src_grant <= '0;
            state         <= StDrain;
          end
        end
        StDrain: begin
          // Hold off new grants until the last byte has left the shifter.
          if (!bus.uart_send && !bus.uart_tx_busy) begin
            rr_ptr <= next_ptr;
            state  <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two sources, short watchdog, simple UART core model.
module tb_uart_tx_arbiter;
  localparam int unsigned N = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic err_clear = 1'b0;
  logic timeout_err, overrun_err;
  int   n_cmp = 0;
  int   n_err = 0;

  uart_tx_arbiter_if #(.N_SRC(N)) bus ();

  uart_tx_arbiter #(
    .N_SRC(N),
    .TIMEOUT_CYCLES(16'd20)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus),
    .err_clear(err_clear),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string tag, input bit ok, input logic [63:0] obs,
                              input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // UART core model: busy for 4 cycles starting the cycle after a send strobe.
  logic [2:0] busy_cnt;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_cnt <= 3'd0;
    else if (bus.uart_send) busy_cnt <= 3'd4;
    else if (busy_cnt != 3'd0) busy_cnt <= busy_cnt - 3'd1;
  end
  assign bus.uart_tx_busy = (busy_cnt != 3'd0);

  // Log of bytes handed to the UART, with the owner at the time.
  logic [7:0] log_byte[$];
  logic [2:0] log_src[$];
  always @(posedge clock) begin
    if (reset_n && bus.uart_send) begin
      log_byte.push_back(bus.uart_byte);
      log_src.push_back(bus.active_src);
    end
  end

  // Structural invariants, checked every cycle out of reset.
  logic prev_send = 1'b0;
  always @(negedge clock) begin
    if (reset_n) begin
      chk("grant_onehot", $onehot0(bus.src_grant) === 1'b1, $onehot0(bus.src_grant), 1'b1);
      chk("send_b2b", (bus.uart_send & prev_send) === 1'b0, bus.uart_send & prev_send, 1'b0);
    end
    prev_send <= reset_n & bus.uart_send;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timed out");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input int s, input logic [7:0] b, input bit last);
    for (int k = 0; k < 40 && bus.src_tx_busy[s]; k++) tick();
    chk("src_free", bus.src_tx_busy[s] === 1'b0, bus.src_tx_busy[s], 1'b0);
    bus.src_byte[8*s +: 8] = b;
    bus.src_send[s] = 1'b1;
    if (last) bus.src_req[s] = 1'b0;
    tick();
    bus.src_send[s] = 1'b0;
    chk("uart_send", bus.uart_send === 1'b1, bus.uart_send, 1'b1);
    chk("uart_byte", bus.uart_byte === b, bus.uart_byte, b);
  endtask

  task automatic wait_grant();
    for (int k = 0; k < 40 && bus.src_grant == '0; k++) tick();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && (bus.uart_tx_busy || bus.uart_send); k++) tick();
    tick();
    tick();
  endtask

  initial begin
    logic [7:0] msg [5];
    msg[0] = "A"; msg[1] = "C"; msg[2] = "S"; msg[3] = "P"; msg[4] = 8'h00;
    bus.src_req  = '0;
    bus.src_byte = '0;
    bus.src_send = '0;
    tick();
    tick();

    // Reset values.
    chk("rst_grant", bus.src_grant === 2'b00, bus.src_grant, 2'b00);
    chk("rst_active", bus.active_src === 3'd0, bus.active_src, 3'd0);
    chk("rst_send", bus.uart_send === 1'b0, bus.uart_send, 1'b0);
    chk("rst_byte", bus.uart_byte === 8'h00, bus.uart_byte, 8'h00);
    chk("rst_txbusy", bus.src_tx_busy === 2'b11, bus.src_tx_busy, 2'b11);
    chk("rst_timeout", timeout_err === 1'b0, timeout_err, 1'b0);
    chk("rst_overrun", overrun_err === 1'b0, overrun_err, 1'b0);
    reset_n = 1'b1;
    tick();

    // Single source, five-byte message; final strobe coincides with the request drop.
    bus.src_req = 2'b01;
    tick();
    chk("s1_grant", bus.src_grant === 2'b01, bus.src_grant, 2'b01);
    chk("s1_active", bus.active_src === 3'd0, bus.active_src, 3'd0);
    chk("s1_txbusy", bus.src_tx_busy === 2'b10, bus.src_tx_busy, 2'b10);
    for (int i = 0; i < 5; i++) send_byte(0, msg[i], i == 4);
    chk("s1_drop", bus.src_grant === 2'b00, bus.src_grant, 2'b00);
    wait_idle();
    chk("s1_logn", log_byte.size() === 5, log_byte.size(), 5);
    for (int i = 0; i < 5 && i < log_byte.size(); i++) begin
      chk("s1_log", log_byte[i] === msg[i], log_byte[i], msg[i]);
      chk("s1_logsrc", log_src[i] === 3'd0, log_src[i], 3'd0);
    end
    log_byte.delete();
    log_src.delete();

    // Contention straight out of reset.
    reset_n = 1'b0;
    #2;
    bus.src_req = 2'b11;
    reset_n = 1'b1;
    tick();
    chk("c_grant0", bus.src_grant === 2'b01, bus.src_grant, 2'b01);
    send_byte(0, "X", 1'b1);
    chk("c_drain", bus.src_grant === 2'b00, bus.src_grant, 2'b00);
    tick();
    chk("c_hold", bus.src_grant === 2'b00, bus.src_grant, 2'b00);
    wait_grant();
    chk("c_grant1", bus.src_grant === 2'b10, bus.src_grant, 2'b10);
    chk("c_uart_free", bus.uart_tx_busy === 1'b0, bus.uart_tx_busy, 1'b0);
    send_byte(1, "Y", 1'b0);
    bus.src_req[1] = 1'b0;
    tick();
    chk("c_drop1", bus.src_grant === 2'b00, bus.src_grant, 2'b00);
    bus.src_req = 2'b11;
    wait_grant();
    chk("c_wrap", bus.src_grant === 2'b01, bus.src_grant, 2'b01);
    chk("c_logn", log_byte.size() === 2, log_byte.size(), 2);
    if (log_byte.size() == 2) begin
      chk("c_log0", {log_src[0], log_byte[0]} === {3'd0, 8'h58}, {log_src[0], log_byte[0]},
          {3'd0, 8'h58});
      chk("c_log1", {log_src[1], log_byte[1]} === {3'd1, 8'h59}, {log_src[1], log_byte[1]},
          {3'd1, 8'h59});
    end
    log_byte.delete();
    log_src.delete();

    // Strobe from the non-granted source is ignored.
    chk("ng_busy_pre", bus.src_tx_busy[1] === 1'b1, bus.src_tx_busy[1], 1'b1);
    bus.src_byte[15:8] = 8'hEE;
    bus.src_send[1] = 1'b1;
    tick();
    bus.src_send[1] = 1'b0;
    chk("ng_send", bus.uart_send === 1'b0, bus.uart_send, 1'b0);
    chk("ng_overrun", overrun_err === 1'b0, overrun_err, 1'b0);
    chk("ng_busy", bus.src_tx_busy[1] === 1'b1, bus.src_tx_busy[1], 1'b1);
    tick();
    chk("ng_send2", bus.uart_send === 1'b0, bus.uart_send, 1'b0);

    // Overrun: strobe while busy, then set-wins and clear.
    send_byte(0, "Z", 1'b0);
    bus.src_byte[7:0] = 8'h55;
    bus.src_send[0] = 1'b1;
    tick();
    bus.src_send[0] = 1'b0;
    chk("ov_send", bus.uart_send === 1'b0, bus.uart_send, 1'b0);
    chk("ov_flag", overrun_err === 1'b1, overrun_err, 1'b1);
    bus.src_send[0] = 1'b1;
    err_clear = 1'b1;
    tick();
    bus.src_send[0] = 1'b0;
    err_clear = 1'b0;
    chk("ov_setwins", overrun_err === 1'b1, overrun_err, 1'b1);
    tick();
    chk("ov_sticky", overrun_err === 1'b1, overrun_err, 1'b1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("ov_clear", overrun_err === 1'b0, overrun_err, 1'b0);
    bus.src_req = 2'b00;
    wait_idle();
    chk("ov_logn", log_byte.size() === 1, log_byte.size(), 1);
    if (log_byte.size() == 1) chk("ov_log", log_byte[0] === 8'h5A, log_byte[0], 8'h5A);
    log_byte.delete();
    log_src.delete();

    // Watchdog: 20 idle granted cycles force a release and lock the source out.
    bus.src_req = 2'b01;
    tick();
    chk("wd_grant", bus.src_grant === 2'b01, bus.src_grant, 2'b01);
    repeat (19) tick();
    chk("wd_before", bus.src_grant === 2'b01, bus.src_grant, 2'b01);
    chk("wd_before_err", timeout_err === 1'b0, timeout_err, 1'b0);
    tick();
    chk("wd_release", bus.src_grant === 2'b00, bus.src_grant, 2'b00);
    chk("wd_err", timeout_err === 1'b1, timeout_err, 1'b1);
    repeat (6) tick();
    chk("wd_lockout", bus.src_grant === 2'b00, bus.src_grant, 2'b00);
    bus.src_req = 2'b00;
    tick();
    bus.src_req = 2'b01;
    tick();
    chk("wd_regrant", bus.src_grant === 2'b01, bus.src_grant, 2'b01);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("wd_clear", timeout_err === 1'b0, timeout_err, 1'b0);

    // Reset in the cycle uart_send is high; rr_ptr was 1 before it.
    bus.src_req = 2'b00;
    wait_idle();
    bus.src_req = 2'b10;
    tick();
    chk("r_grant1", bus.src_grant === 2'b10, bus.src_grant, 2'b10);
    chk("r_active1", bus.active_src === 3'd1, bus.active_src, 3'd1);
    send_byte(1, 8'hA5, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("r_send", bus.uart_send === 1'b0, bus.uart_send, 1'b0);
    chk("r_grant", bus.src_grant === 2'b00, bus.src_grant, 2'b00);
    chk("r_active", bus.active_src === 3'd0, bus.active_src, 3'd0);
    chk("r_byte", bus.uart_byte === 8'h00, bus.uart_byte, 8'h00);
    chk("r_txbusy", bus.src_tx_busy === 2'b11, bus.src_tx_busy, 2'b11);
    bus.src_req = 2'b11;
    #2;
    reset_n = 1'b1;
    tick();
    chk("r_restart", bus.src_grant === 2'b01, bus.src_grant, 2'b01);
    chk("r_restart_src", bus.active_src === 3'd0, bus.active_src, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
